// File: rtl/csat_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csat_sched_pkg
// Description : Shared types and default widths for the CSAT enumeration
//               scheduler and its tag pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package csat_sched_pkg;

  // Default candidate width: a[7:0] and b[4:0] packed as {a,b}
  localparam int c_def_n_in  = 13;
  // Default checker latency from cand_valid to sat_valid
  localparam int c_def_lat   = 2;
  // One extra bit so a full 2^N_IN sweep can be counted without wrap
  localparam int c_def_cnt_w = c_def_n_in + 1;

  // Search controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

endpackage : csat_sched_pkg
`default_nettype wire

// File: rtl/csat_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : csat_tag_pipe
// Description : DEPTH-deep shift register of {valid,tag}. Carries each issued
//               candidate alongside the checker so the returning result can be
//               attributed to it. Bubbles travel as valid=0 entries.
// Revision    : 1.0 - initial release
// ============================================================================
module csat_tag_pipe #(
  parameter int W     = 13,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_tag,
  output logic         tail_valid,
  output logic [W-1:0] tail_tag,
  output logic         empty,
  output logic         head_empty
);

  logic [DEPTH-1:0] r_valid;
  logic [W-1:0]     r_tag [DEPTH];

  // Shift every stage by one each cycle; stage 0 takes the new issue or a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_valid[0] <= in_valid;
      r_tag[0]   <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  assign tail_valid = r_valid[DEPTH-1];
  assign tail_tag   = r_tag[DEPTH-1];
  assign empty      = ~|r_valid;

  // head_empty: nothing in flight behind the tail entry
  generate
    if (DEPTH > 1) begin : g_head
      assign head_empty = ~|r_valid[DEPTH-2:0];
    end else begin : g_head_none
      assign head_empty = 1'b1;
    end
  endgenerate

endmodule : csat_tag_pipe
`default_nettype wire

// File: rtl/csat_enum_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : csat_enum_scheduler
// Description : Sequential search controller for a combinational CSAT miter.
//               Issues candidates base..limit one per cycle to a fixed-latency
//               checker, attributes returned sat bits via a tag pipeline and
//               stops on the first hit, on exhaustion, or on abort.
// Revision    : 1.0 - initial release
// ============================================================================
module csat_enum_scheduler
  import csat_sched_pkg::*;
#(
  parameter int N_IN  = c_def_n_in,
  parameter int LAT   = c_def_lat,
  parameter int CNT_W = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [N_IN-1:0]  base,
  input  logic [N_IN-1:0]  limit,
  output logic [N_IN-1:0]  cand,
  output logic             cand_valid,
  input  logic             sat_in,
  input  logic             sat_valid,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             aborted,
  output logic [N_IN-1:0]  solution,
  output logic [CNT_W-1:0] tried
);

  sched_state_e     r_state;
  sched_state_e     w_next_state;

  logic [N_IN-1:0]  r_ptr;
  logic [N_IN-1:0]  r_limit;
  logic [N_IN-1:0]  r_solution;
  logic             r_found;
  logic             r_aborted;
  logic [CNT_W-1:0] r_tried;

  logic             w_active;
  logic             w_kill;
  logic             w_retire;
  logic             w_hit;
  logic             w_at_limit;

  logic             w_tail_valid;
  logic [N_IN-1:0]  w_tail_tag;
  logic             w_pipe_empty;
  logic             w_head_empty;

  // Abort dominates both issue and retirement in the cycle it is seen
  assign w_active   = (r_state == RUN) || (r_state == DRAIN);
  assign w_kill     = w_active && abort;
  assign w_retire   = w_active && !abort && sat_valid;
  assign w_hit      = w_retire && sat_in;
  // Compare before incrementing so limit = all-ones never wraps the pointer
  assign w_at_limit = (r_ptr == r_limit);

  csat_tag_pipe #(
    .W     (N_IN),
    .DEPTH (LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (cand_valid),
    .in_tag     (r_ptr),
    .tail_valid (w_tail_valid),
    .tail_tag   (w_tail_tag),
    .empty      (w_pipe_empty),
    .head_empty (w_head_empty)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; a hit ends the search ahead of reaching the limit
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = (base > limit) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_kill || w_hit) begin
          w_next_state = DONE;
        end else if (cand_valid && w_at_limit) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        // Leave once nothing remains behind the entry retiring this cycle
        if (w_kill || w_hit || w_head_empty || w_pipe_empty) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State-decoded outputs; issue is suppressed by pause and by abort
  always_comb begin
    cand_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      RUN: begin
        busy       = 1'b1;
        cand_valid = !pause && !abort;
      end
      DRAIN: begin
        busy = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Search datapath: pointer, bounds, result flags and retirement counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_limit    <= '0;
      r_solution <= '0;
      r_found    <= 1'b0;
      r_aborted  <= 1'b0;
      r_tried    <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_ptr     <= base;
        r_limit   <= limit;
        r_found   <= 1'b0;
        r_aborted <= 1'b0;
        r_tried   <= '0;
      end
      if (cand_valid && !w_at_limit) begin
        r_ptr <= r_ptr + N_IN'(1);
      end
      if (w_retire) begin
        r_tried <= r_tried + CNT_W'(1);
      end
      if (w_hit) begin
        r_found    <= 1'b1;
        r_solution <= w_tail_tag;
      end
      if (w_kill) begin
        r_aborted <= 1'b1;
        r_found   <= 1'b0;
      end
    end
  end

  assign cand     = r_ptr;
  assign found    = r_found;
  assign aborted  = r_aborted;
  assign solution = r_solution;
  assign tried    = r_tried;

  // A returning result must line up with a live tag leaving the pipe
  a_lat_align : assert property (@(posedge clk) disable iff (!rst_n)
                                 sat_valid == w_tail_valid);

endmodule : csat_enum_scheduler
`default_nettype wire

// File: tb/tb_csat_enum_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_csat_enum_scheduler
// Description : Randomized scoreboard bench for csat_enum_scheduler with a
//               fixed-latency miter model and a range-search reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csat_enum_scheduler;

  localparam int N_IN  = 13;
  localparam int LAT   = 2;
  localparam int CNT_W = N_IN + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             pause = 1'b0;
  logic [N_IN-1:0]  base = '0;
  logic [N_IN-1:0]  limit = '0;
  logic [N_IN-1:0]  cand;
  logic             cand_valid;
  logic             sat_in;
  logic             sat_valid;
  logic             busy;
  logic             done;
  logic             found;
  logic             aborted;
  logic [N_IN-1:0]  solution;
  logic [CNT_W-1:0] tried;

  always #5 clk = ~clk;

  csat_enum_scheduler #(
    .N_IN  (N_IN),
    .LAT   (LAT),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .pause      (pause),
    .base       (base),
    .limit      (limit),
    .cand       (cand),
    .cand_valid (cand_valid),
    .sat_in     (sat_in),
    .sat_valid  (sat_valid),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .aborted    (aborted),
    .solution   (solution),
    .tried      (tried)
  );

  // ---------------- checker model: sat when candidate hits a target --------
  int tgt0 = -1;
  int tgt1 = -1;

  function automatic bit is_sat(input int x, input int a, input int b);
    return (x == a) || (x == b);
  endfunction

  logic [LAT-1:0]  ck_v;
  logic [N_IN-1:0] ck_c [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_v <= '0;
      for (int i = 0; i < LAT; i++) ck_c[i] <= '0;
    end else begin
      ck_v    <= {ck_v[LAT-2:0], cand_valid};
      ck_c[0] <= cand;
      for (int i = 1; i < LAT; i++) ck_c[i] <= ck_c[i-1];
    end
  end

  assign sat_valid = ck_v[LAT-1];
  assign sat_in    = ck_v[LAT-1] && is_sat(int'(ck_c[LAT-1]), tgt0, tgt1);

  // ---------------- scoreboard ---------------------------------------------
  typedef struct {
    bit found;
    int sol;
    int tried;
    bit aborted;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ------------------------------------------------
  int   cyc = 0;
  int   exp_next = 0;
  int   last_issue_cyc = 0;
  int   done_cyc = 0;
  int   done_cnt = 0;
  bit   prev_done = 0;
  exp_t e_mon;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (prev_done) chk("busy_after_done", busy, 0);
      if (cand_valid) begin
        chk("cand_order", int'(cand), exp_next);
        chk("issue_while_busy", busy & ~done, 1);
        exp_next++;
        last_issue_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          e_mon = sb.pop_front();
          chk("found", int'(found), int'(e_mon.found));
          chk("aborted", int'(aborted), int'(e_mon.aborted));
          chk("tried", int'(tried), e_mon.tried);
          if (e_mon.found) chk("solution", int'(solution), e_mon.sol);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 0;
    end
  end

  // ---------------- stimulus -----------------------------------------------
  task automatic check_reset_outputs();
    chk("rst_cand", int'(cand), 0);
    chk("rst_cand_valid", int'(cand_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_solution", int'(solution), 0);
    chk("rst_tried", int'(tried), 0);
  endtask

  // Reference: first satisfying value in [b,l] decides found/solution/tried
  function automatic exp_t ref_model(input int b, input int l, input int t0,
                                     input int t1, input bit abort_hit);
    exp_t e;
    int   first;
    first     = -1;
    e.found   = 0;
    e.sol     = 0;
    e.aborted = 0;
    e.tried   = 0;
    if (b <= l) begin
      for (int x = b; x <= l; x++) begin
        if (is_sat(x, t0, t1)) begin
          first = x;
          break;
        end
      end
      if (first >= 0 && abort_hit) begin
        e.aborted = 1;
        e.tried   = first - b;
      end else if (first >= 0) begin
        e.found = 1;
        e.sol   = first;
        e.tried = first - b + 1;
      end else begin
        e.tried = l - b + 1;
      end
    end
    return e;
  endfunction

  // pmode: 0 none, 1 pause every other cycle, 2 random pause and stray starts
  task automatic run_search(input int b, input int l, input int t0, input int t1,
                            input int pmode, input bit abort_hit,
                            output int elapsed);
    int d0;
    int ncyc;
    tgt0     = t0;
    tgt1     = t1;
    base     = N_IN'(b);
    limit    = N_IN'(l);
    exp_next = b;
    sb.push_back(ref_model(b, l, t0, t1, abort_hit));
    d0    = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ncyc  = 0;
    while (done_cnt == d0 && ncyc < 20000) begin
      case (pmode)
        1:       pause = (ncyc % 2 == 0);
        2: begin
          pause = ($urandom % 3 == 0);
          start = ($urandom % 8 == 0);
          base  = N_IN'($urandom);
        end
        default: pause = 1'b0;
      endcase
      abort = abort_hit && sat_valid && sat_in;
      @(posedge clk);
      #1;
      ncyc++;
    end
    pause = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL search_timeout: got no done after %0d cycles expected a done pulse", ncyc);
    end
    elapsed = ncyc;
  endtask

  initial begin
    int   el1;
    int   elp;
    int   dmy;
    int   b;
    int   l;
    int   d0;
    exp_t er;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First hit at 0x0A5 from a full-range sweep
    run_search(0, 'h1FFF, 'h0A5, -1, 0, 0, el1);
    // No hit: full drain to the top of the space, no pointer wrap
    run_search('h0A6, 'h1FFF, 'h0A5, -1, 0, 0, dmy);
    chk("drain_done_after_last_result", done_cyc - last_issue_cyc, LAT + 1);
    // Hit on the final candidate reported through the drain path
    run_search('h0A0, 'h0A5, 'h0A5, -1, 0, 0, dmy);
    // Alternating pause: same result, one extra cycle per issued candidate
    run_search(0, 'h1FFF, 'h0A5, -1, 1, 0, elp);
    chk("pause_run_length", elp, el1 + 'hA6);
    // Abort coinciding with the hit on candidate base+2
    run_search('h300, 'h1FFF, 'h302, -1, 0, 1, dmy);
    // Empty range
    run_search('h40, 'h3F, 'h40, -1, 0, 0, dmy);
    // Hit on limit at the very top of the space
    run_search('h1FFC, 'h1FFF, 'h1FFF, -1, 0, 0, dmy);

    // Abort while idle has no effect
    d0    = done_cnt;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_abort_no_done", done_cnt, d0);
    chk("idle_abort_not_busy", int'(busy), 0);

    // Randomized searches
    for (int k = 0; k < 14; k++) begin
      b = int'($urandom_range(0, 8191));
      l = b + int'($urandom_range(0, 40));
      if (l > 8191) l = 8191;
      if ($urandom % 6 == 0 && b > 0) l = b - 1;
      run_search(b, l,
                 ($urandom % 4 == 0) ? -1 : b + int'($urandom_range(0, 50)),
                 ($urandom % 2 == 0) ? -1 : b + int'($urandom_range(0, 50)),
                 2, ($urandom % 4 == 0), dmy);
    end

    // Reset mid-run
    tgt0     = 'h1800;
    tgt1     = -1;
    base     = '0;
    limit    = 'h1FFF;
    exp_next = 0;
    er       = ref_model(0, 'h1FFF, 'h1800, -1, 0);
    sb.push_back(er);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    chk("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Fresh search after reset release
    run_search('h10, 'h40, 'h33, -1, 2, 0, dmy);

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "global timeout");
  end

endmodule : tb_csat_enum_scheduler
`default_nettype wire
